pixel_wr_packer: RTL and testbench

//  Downstream of the grayscale/convolution pipeline. Takes the 12-bit RGB pixel stream and its

---
 rtl/pixel_wr_packer.sv | 217 +++++++++++++++++++++
 tb/tb_pixel_wr_packer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_wr_packer.sv
// pixel_wr_packer
// Packs each 12-bit RGB pixel into a pair of 16-bit SDRAM write words, queues the pairs
// in a show-ahead FIFO drained through a valid/ready handshake, and tracks frame progress
// (pixel count, frame-done pulse, drop count, sticky overflow).
module pixel_wr_packer #(
    parameter int DEPTH        = 16,
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 20
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [11:0]      iRed,
    input  logic [11:0]      iGreen,
    input  logic [11:0]      iBlue,
    input  logic             iDVAL,
    input  logic             iSOF,
    input  logic             iWR_READY,
    output logic [15:0]      oWR1_DATA,
    output logic [15:0]      oWR2_DATA,
    output logic             oWR_EN,
    output logic [CNT_W-1:0] oPIX_CNT,
    output logic [CNT_W-1:0] oDROP_CNT,
    output logic             oOVERFLOW,
    output logic             oFRAME_DONE
);

    localparam int                AW         = $clog2(DEPTH);
    localparam logic [AW:0]       LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [15:0]       wr1_q, wr1_d;
    logic [15:0]       wr2_q, wr2_d;
    logic              wr_en_q, wr_en_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              in_frame_s;
    logic              pix_evt_s;
    logic [CNT_W-1:0]  pix_base_s;
    logic [CNT_W-1:0]  pix_inc_s;
    logic [CNT_W-1:0]  drop_base_s;
    logic              frame_end_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              bypass_s;
    logic [31:0]       pack_s;
    logic              unused_lsb_s;

    // Truncating pack: word1 in [31:16], word2 in [15:0]; two LSBs of each component are discarded.
    always_comb begin
        pack_s       = {1'b0, iGreen[11:7], iBlue[11:2], 1'b0, iGreen[6:2], iRed[11:2]};
        unused_lsb_s = ^{iRed[1:0], iGreen[1:0], iBlue[1:0]};
    end

    // Frame FSM state register.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state: iSOF always (re)starts a frame, the last pixel closes it.
    always_comb begin
        state_d = state_q;
        if (iSOF) begin
            state_d = frame_end_s ? ST_DONE : ST_ACTIVE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_ACTIVE: state_d = frame_end_s ? ST_DONE : ST_ACTIVE;
                ST_DONE:   state_d = ST_DONE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Frame FSM outputs: a pixel belongs to a frame when ACTIVE or when entering ACTIVE this cycle.
    always_comb begin
        in_frame_s = 1'b0;
        case (state_q)
            ST_ACTIVE: in_frame_s = 1'b1;
            ST_IDLE:   in_frame_s = iSOF;
            ST_DONE:   in_frame_s = iSOF;
            default:   in_frame_s = 1'b0;
        endcase
        pix_evt_s = in_frame_s && iDVAL;
    end

    // Pixel counting: iSOF restarts from zero, so a pixel arriving with iSOF is pixel 1.
    always_comb begin
        pix_base_s  = iSOF ? {CNT_W{1'b0}} : pix_cnt_q;
        pix_inc_s   = pix_base_s + CNT_W'(1);
        frame_end_s = pix_evt_s && (pix_inc_s == FRAME_LAST);
        if (pix_evt_s) begin
            pix_cnt_d = pix_inc_s;
        end else begin
            pix_cnt_d = pix_base_s;
        end
        done_d = frame_end_s;
    end

    // FIFO handshake: a full FIFO still accepts a pixel when the head leaves in the same cycle.
    always_comb begin
        full_s  = (level_q == LEVEL_FULL);
        empty_s = (level_q == {(AW+1){1'b0}});
        pop_s   = !empty_s && iWR_READY;
        push_s  = pix_evt_s && (!full_s || pop_s);
        drop_s  = pix_evt_s && !push_s;
    end

    // FIFO pointers and level; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Show-ahead output stage: preload the next head, bypassing the array when the
    // incoming pixel becomes the head in the same cycle it is written.
    always_comb begin
        bypass_s = push_s && (wr_ptr_q == rd_ptr_d);
        wr_en_d  = (level_d != {(AW+1){1'b0}});
        if (!wr_en_d) begin
            wr1_d = 16'h0000;
            wr2_d = 16'h0000;
        end else if (bypass_s) begin
            wr1_d = pack_s[31:16];
            wr2_d = pack_s[15:0];
        end else begin
            wr1_d = mem_q[rd_ptr_d][31:16];
            wr2_d = mem_q[rd_ptr_d][15:0];
        end
    end

    // Drop accounting: saturating counter plus sticky flag, both restarted by iSOF.
    always_comb begin
        drop_base_s = iSOF ? {CNT_W{1'b0}} : drop_cnt_q;
        if (drop_s && (drop_base_s != CNT_MAX)) begin
            drop_cnt_d = drop_base_s + CNT_W'(1);
        end else begin
            drop_cnt_d = drop_base_s;
        end
        ovf_d = (iSOF ? 1'b0 : ovf_q) | drop_s;
    end

    // FIFO storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge iCLK) begin
        if (iRST_N && push_s) begin
            mem_q[wr_ptr_q] <= pack_s;
        end
    end

    // FIFO control, output stage and frame counters.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {(AW+1){1'b0}};
            wr1_q      <= 16'h0000;
            wr2_q      <= 16'h0000;
            wr_en_q    <= 1'b0;
            pix_cnt_q  <= {CNT_W{1'b0}};
            drop_cnt_q <= {CNT_W{1'b0}};
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr1_q      <= wr1_d;
            wr2_q      <= wr2_d;
            wr_en_q    <= wr_en_d;
            pix_cnt_q  <= pix_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign oWR1_DATA   = wr1_q;
    assign oWR2_DATA   = wr2_q;
    assign oWR_EN      = wr_en_q;
    assign oPIX_CNT    = pix_cnt_q;
    assign oDROP_CNT   = drop_cnt_q;
    assign oOVERFLOW   = ovf_q;
    assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_pixel_wr_packer.sv
// Self-checking bench for pixel_wr_packer: a vector table for reset, packing and latency,
// plus hand-written sequences for backpressure, full-with-pop, frame end and reset mid-drain.
module tb_pixel_wr_packer;

    logic        clk = 1'b0;
    logic        rst_n, sof, dval, rdy;
    logic [11:0] r, g, b;

    logic [15:0] w1, w2, f_w1, f_w2;
    logic        en, ovf, done, f_en, f_ovf, f_done;
    logic [19:0] pix, drop, f_pix, f_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_wr_packer #(.DEPTH(16), .FRAME_PIXELS(307200), .CNT_W(20)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iRed(r), .iGreen(g), .iBlue(b),
        .iDVAL(dval), .iSOF(sof), .iWR_READY(rdy),
        .oWR1_DATA(w1), .oWR2_DATA(w2), .oWR_EN(en), .oPIX_CNT(pix),
        .oDROP_CNT(drop), .oOVERFLOW(ovf), .oFRAME_DONE(done)
    );

    // Short-frame, shallow-FIFO instance for the frame-end scenario.
    pixel_wr_packer #(.DEPTH(4), .FRAME_PIXELS(8), .CNT_W(20)) dut_f (
        .iCLK(clk), .iRST_N(rst_n), .iRed(r), .iGreen(g), .iBlue(b),
        .iDVAL(dval), .iSOF(sof), .iWR_READY(rdy),
        .oWR1_DATA(f_w1), .oWR2_DATA(f_w2), .oWR_EN(f_en), .oPIX_CNT(f_pix),
        .oDROP_CNT(f_drop), .oOVERFLOW(f_ovf), .oFRAME_DONE(f_done)
    );

    typedef struct {
        logic        rst_n, sof, dval;
        logic [11:0] r, g, b;
        logic        rdy;
        logic        en;
        logic [15:0] w1, w2;
        logic [19:0] pix, drop;
        logic        ovf;
    } vec_t;

    vec_t vt[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Indexed test pixel: components chosen so each packed field encodes the index.
    task automatic set_idx(input int i);
        r = {10'(i), 2'b11};
        g = {5'(i), 5'(i + 7), 2'b01};
        b = {10'(i + 100), 2'b10};
    endtask

    function automatic logic [15:0] exp_w1(input int i);
        return {1'b0, 5'(i), 10'(i + 100)};
    endfunction

    function automatic logic [15:0] exp_w2(input int i);
        return {1'b0, 5'(i + 7), 10'(i)};
    endfunction

    initial begin
        rst_n = 1'b0; sof = 1'b0; dval = 1'b0; rdy = 1'b0;
        r = 12'h000; g = 12'h000; b = 12'h000;

        // rst_n sof dval r g b rdy | en w1 w2 pix drop ovf
        vt[0]  = '{1'b0, 1'b0, 1'b1, 12'h111, 12'h222, 12'h333, 1'b0, 1'b0, 16'h0000, 16'h0000, 20'd0, 20'd0, 1'b0};
        vt[1]  = vt[0];
        for (int i = 2; i <= 6; i++)
            vt[i] = '{1'b1, 1'b0, 1'b1, 12'h444, 12'h555, 12'h666, 1'b0, 1'b0, 16'h0000, 16'h0000, 20'd0, 20'd0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 12'hFFF, 12'hABC, 12'h123, 1'b1, 1'b1, 16'h5448, 16'h3FFF, 20'd1, 20'd0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0, 16'h0000, 16'h0000, 20'd1, 20'd0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 12'h000, 12'hFFF, 12'hFFF, 1'b0, 1'b1, 16'h7FFF, 16'h7C00, 20'd2, 20'd0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b1, 12'h800, 12'h003, 12'h7FF, 1'b0, 1'b1, 16'h7FFF, 16'h7C00, 20'd3, 20'd0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 1'b1, 16'h01FF, 16'h0200, 20'd3, 20'd0, 1'b0};
        vt[12] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0, 16'h0000, 16'h0000, 20'd3, 20'd0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0, 16'h0000, 16'h0000, 20'd0, 20'd0, 1'b0};

        // Reset, idle-ignore, packing, latency, hold under backpressure, mid-frame iSOF.
        for (int i = 0; i < 14; i++) begin
            rst_n = vt[i].rst_n; sof = vt[i].sof; dval = vt[i].dval;
            r = vt[i].r; g = vt[i].g; b = vt[i].b; rdy = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d_en", i),   32'(en),   32'(vt[i].en));
            chk($sformatf("vec%0d_wr1", i),  32'(w1),   32'(vt[i].w1));
            chk($sformatf("vec%0d_wr2", i),  32'(w2),   32'(vt[i].w2));
            chk($sformatf("vec%0d_pix", i),  32'(pix),  32'(vt[i].pix));
            chk($sformatf("vec%0d_drop", i), 32'(drop), 32'(vt[i].drop));
            chk($sformatf("vec%0d_ovf", i),  32'(ovf),  32'(vt[i].ovf));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'd0);
        end

        // Backpressure: 19 pixels into a 16-deep FIFO, then drain in order.
        sof = 1'b0; rdy = 1'b0; dval = 1'b1;
        for (int i = 0; i < 19; i++) begin
            set_idx(i);
            tick();
            chk($sformatf("bp_pix%0d", i),  32'(pix),  32'(i + 1));
            chk($sformatf("bp_drop%0d", i), 32'(drop), (i < 16) ? 32'd0 : 32'(i - 15));
            chk($sformatf("bp_ovf%0d", i),  32'(ovf),  (i < 16) ? 32'd0 : 32'd1);
        end
        dval = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("bp_en%0d", k),  32'(en), 32'd1);
            chk($sformatf("bp_wr1_%0d", k), 32'(w1), 32'(exp_w1(k)));
            chk($sformatf("bp_wr2_%0d", k), 32'(w2), 32'(exp_w2(k)));
            tick();
        end
        chk("bp_empty", 32'(en), 32'd0);

        // Full with simultaneous pop: no drops, level stays at DEPTH.
        sof = 1'b1; rdy = 1'b0; dval = 1'b0;
        tick();
        sof = 1'b0; dval = 1'b1;
        for (int j = 0; j < 16; j++) begin
            set_idx(100 + j);
            tick();
        end
        chk("fp_fill_drop", 32'(drop), 32'd0);
        rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_idx(116 + c);
            tick();
            chk($sformatf("fp_drop%0d", c), 32'(drop), 32'd0);
            chk($sformatf("fp_en%0d", c),   32'(en),   32'd1);
            chk($sformatf("fp_wr1_%0d", c), 32'(w1),   32'(exp_w1(101 + c)));
        end
        rdy = 1'b0;
        set_idx(126);
        tick();
        chk("fp_still_full_drop", 32'(drop), 32'd1);
        chk("fp_still_full_ovf",  32'(ovf),  32'd1);
        dval = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fp_drain_wr1_%0d", k), 32'(w1), 32'(exp_w1(110 + k)));
            chk($sformatf("fp_drain_wr2_%0d", k), 32'(w2), 32'(exp_w2(110 + k)));
            tick();
        end
        chk("fp_drain_empty", 32'(en), 32'd0);

        // Reset mid-drain discards the FIFO and returns to IDLE.
        sof = 1'b1; dval = 1'b0; rdy = 1'b0;
        tick();
        sof = 1'b0; dval = 1'b1;
        for (int j = 0; j < 5; j++) begin
            set_idx(300 + j);
            tick();
        end
        chk("rm_pre_en",  32'(en),  32'd1);
        chk("rm_pre_pix", 32'(pix), 32'd5);
        rst_n = 1'b0;
        tick();
        chk("rm_en",   32'(en),   32'd0);
        chk("rm_wr1",  32'(w1),   32'd0);
        chk("rm_wr2",  32'(w2),   32'd0);
        chk("rm_pix",  32'(pix),  32'd0);
        chk("rm_drop", 32'(drop), 32'd0);
        chk("rm_ovf",  32'(ovf),  32'd0);
        chk("rm_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            chk($sformatf("rm_idle_en%0d", j),  32'(en),  32'd0);
            chk($sformatf("rm_idle_pix%0d", j), 32'(pix), 32'd0);
        end

        // Frame end on the short-frame instance (DEPTH=4, FRAME_PIXELS=8).
        rst_n = 1'b0; dval = 1'b0; rdy = 1'b0;
        tick();
        rst_n = 1'b1; sof = 1'b1;
        tick();
        chk("fe_start_pix", 32'(f_pix), 32'd0);
        sof = 1'b0; dval = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            set_idx(200 + n);
            tick();
            chk($sformatf("fe_pix%0d", n),  32'(f_pix),  (n <= 8) ? 32'(n) : 32'd8);
            chk($sformatf("fe_done%0d", n), 32'(f_done), (n == 8) ? 32'd1 : 32'd0);
            chk($sformatf("fe_drop%0d", n), 32'(f_drop), (n <= 4) ? 32'd0 : ((n <= 8) ? 32'(n - 4) : 32'd4));
            chk($sformatf("fe_ovf%0d", n),  32'(f_ovf),  (n >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("fe_en%0d", n),   32'(f_en),   32'd1);
        end
        dval = 1'b0; sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("fe_sof_pix",  32'(f_pix),  32'd0);
        chk("fe_sof_drop", 32'(f_drop), 32'd0);
        chk("fe_sof_ovf",  32'(f_ovf),  32'd0);
        chk("fe_sof_done", 32'(f_done), 32'd0);
        chk("fe_sof_en",   32'(f_en),   32'd1);
        rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fe_drain_wr1_%0d", k), 32'(f_w1), 32'(exp_w1(201 + k)));
            chk($sformatf("fe_drain_wr2_%0d", k), 32'(f_w2), 32'(exp_w2(201 + k)));
            tick();
        end
        chk("fe_drain_empty", 32'(f_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
